// File: rtl/trng_word_packer_if.sv
// Bus between a ring-oscillator sampler and the TRNG word packer:
// collection control and raw samples in, packed random words and status out.
interface trng_word_packer_if;
  logic        enable_TRO;
  logic        raw_bit;
  logic        raw_valid;
  logic [63:0] random_reg;
  logic        rng_ready;
  logic        tro_stuck;

  modport master (
    output enable_TRO, raw_bit, raw_valid,
    input  random_reg, rng_ready, tro_stuck
  );

  modport slave (
    input  enable_TRO, raw_bit, raw_valid,
    output random_reg, rng_ready, tro_stuck
  );
endinterface

// File: rtl/trng_word_packer.sv
// Packs (optionally von Neumann debiased) ring-oscillator bits into 64-bit
// random words, with a post-word idle gap and a sticky stuck-source detector.
module trng_word_packer #(
  parameter int VN_EN       = 1,
  parameter int GAP_CYCLES  = 6,
  parameter int STUCK_LIMIT = 128
) (
  input logic                 clk,
  input logic                 trng_rst_n,
  trng_word_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LOAD_C  = 8'(GAP_CYCLES);
  localparam logic [9:0] STUCK_LIM_C = 10'(STUCK_LIMIT);

  state_t      state_r;
  logic [63:0] shift_r;
  logic [5:0]  bit_cnt_r;
  logic [7:0]  gap_cnt_r;
  logic        pend_r;
  logic        first_r;
  logic        prev_valid_r;
  logic        prev_bit_r;
  logic [9:0]  stuck_cnt_r;
  logic [63:0] random_reg_r;
  logic        rng_ready_r;
  logic        tro_stuck_r;

  logic        acc_s;
  logic        acc_bit_s;
  logic        stuck_upd_s;
  logic [9:0]  stuck_nxt_s;

  function automatic logic [9:0] sat_inc(input logic [9:0] c);
    return (c == 10'h3FF) ? c : c + 10'd1;
  endfunction

  // Decide whether this sample yields an accepted bit and how the stuck run evolves.
  always_comb begin
    acc_s       = 1'b0;
    acc_bit_s   = bus.raw_bit;
    stuck_upd_s = 1'b0;
    stuck_nxt_s = stuck_cnt_r;
    if (state_r == COLLECT && bus.enable_TRO && bus.raw_valid) begin
      if (VN_EN != 32'sd0) begin
        if (pend_r) begin
          stuck_upd_s = 1'b1;
          if (first_r != bus.raw_bit) begin
            acc_s       = 1'b1;
            acc_bit_s   = first_r;
            stuck_nxt_s = 10'd0;
          end else begin
            stuck_nxt_s = sat_inc(stuck_cnt_r);
          end
        end else begin
          acc_s = 1'b0;
        end
      end else begin
        acc_s       = 1'b1;
        stuck_upd_s = 1'b1;
        // Raw mode: the run spans word boundaries, so the last bit survives the gap.
        if (prev_valid_r && (prev_bit_r == bus.raw_bit)) begin
          stuck_nxt_s = sat_inc(stuck_cnt_r);
        end else begin
          stuck_nxt_s = 10'd0;
        end
      end
    end else begin
      stuck_upd_s = 1'b0;
    end
  end

  // Packer state machine, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge trng_rst_n) begin
    if (!trng_rst_n) begin
      state_r      <= IDLE;
      shift_r      <= 64'd0;
      bit_cnt_r    <= 6'd0;
      gap_cnt_r    <= 8'd0;
      pend_r       <= 1'b0;
      first_r      <= 1'b0;
      prev_valid_r <= 1'b0;
      prev_bit_r   <= 1'b0;
      stuck_cnt_r  <= 10'd0;
      random_reg_r <= 64'd0;
      rng_ready_r  <= 1'b0;
      tro_stuck_r  <= 1'b0;
    end else begin
      rng_ready_r <= 1'b0;
      if (stuck_upd_s) begin
        stuck_cnt_r <= stuck_nxt_s;
        if (stuck_nxt_s >= STUCK_LIM_C) begin
          tro_stuck_r <= 1'b1;
        end
      end
      case (state_r)
        IDLE: begin
          pend_r    <= 1'b0;
          bit_cnt_r <= 6'd0;
          if (bus.enable_TRO) begin
            state_r <= COLLECT;
          end
        end
        COLLECT: begin
          if (!bus.enable_TRO) begin
            state_r   <= IDLE;
            pend_r    <= 1'b0;
            bit_cnt_r <= 6'd0;
          end else if (bus.raw_valid) begin
            if (VN_EN != 32'sd0) begin
              pend_r <= ~pend_r;
              if (!pend_r) begin
                first_r <= bus.raw_bit;
              end
            end else begin
              prev_valid_r <= 1'b1;
              prev_bit_r   <= bus.raw_bit;
            end
            if (acc_s) begin
              shift_r   <= {shift_r[62:0], acc_bit_s};
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == 6'd63) begin
                state_r      <= PRESENT;
                random_reg_r <= {shift_r[62:0], acc_bit_s};
                rng_ready_r  <= 1'b1;
              end
            end
          end
        end
        PRESENT: begin
          state_r   <= GAP;
          gap_cnt_r <= GAP_LOAD_C;
          pend_r    <= 1'b0;
          bit_cnt_r <= 6'd0;
        end
        GAP: begin
          if (gap_cnt_r == 8'd1) begin
            state_r <= bus.enable_TRO ? COLLECT : IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.random_reg = random_reg_r;
  assign bus.rng_ready  = rng_ready_r;
  assign bus.tro_stuck  = tro_stuck_r;

endmodule

// File: doc/trng_word_packer.md
TRNG_WORD_PACKER -- requirements
Module: trng_word_packer

Interface
REQ-001 Parameter VN_EN, default 1, meaning: 1 enables von Neumann debiasing of raw pairs, 0 passes raw bits straight through.
REQ-002 Parameter GAP_CYCLES, default 6, meaning: idle cycles after each word, range 1..255.
REQ-003 Parameter STUCK_LIMIT, default 128, meaning: consecutive discarded equal pairs that flag a stuck oscillator, range 2..1023.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 trng_rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable_TRO  input  1  collection enable from the statistical test.
REQ-007 raw_bit  input  1  sampled ring-oscillator bit, valid when raw_valid=1.
REQ-008 raw_valid  input  1  one-cycle strobe qualifying raw_bit.
REQ-009 random_reg  output  64  last completed random word.
REQ-010 rng_ready  output  1  one-cycle pulse; random_reg is new and valid.
REQ-011 tro_stuck  output  1  sticky stuck-source flag.

Function
REQ-012 FSM states SHALL be IDLE, COLLECT, PRESENT and GAP.
REQ-013 IDLE SHALL go to COLLECT on the first cycle with enable_TRO=1.
REQ-014 In COLLECT with VN_EN=0, every raw_valid cycle SHALL yield one accepted bit equal to raw_bit.
REQ-015 With VN_EN=1, raw_valid samples SHALL pair in arrival order (first, second).
REQ-016 A differing pair SHALL yield one accepted bit equal to the first bit; an equal pair SHALL yield nothing.
REQ-017 Accepted bits SHALL shift into a 64-bit shift register from the LSB, so the first accepted bit lands in bit 63.
REQ-018 A 6-bit accepted-bit counter SHALL wrap from 63 to 0 when the 64th bit is accepted.
REQ-019 On the 64th accepted bit, the FSM SHALL enter PRESENT on the next edge.
REQ-020 On that same next edge, random_reg SHALL load the full shift register.
REQ-021 rng_ready SHALL be 1 only during the single PRESENT cycle, giving latency 1 cycle from the 64th bit's raw_valid.
REQ-022 random_reg SHALL hold its value until the next word completes.
REQ-023 PRESENT SHALL always go to GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, counted by a down-counter.
REQ-025 raw_valid SHALL be ignored in PRESENT and GAP.
REQ-026 The pair buffer and bit counter SHALL be cleared on entry to GAP.
REQ-027 GAP SHALL exit to COLLECT if enable_TRO=1, else to IDLE.
REQ-028 enable_TRO=0 in COLLECT SHALL return the FSM to IDLE on the next edge.
REQ-029 That abort SHALL discard the partial word and any pending first-of-pair bit, and SHALL leave random_reg unchanged.
REQ-030 If raw_valid and enable_TRO falling coincide in COLLECT, the sample SHALL be dropped.
REQ-031 An equal pair SHALL increment a saturating 10-bit stuck counter; a differing pair SHALL clear it.
REQ-032 tro_stuck SHALL set when the stuck counter reaches STUCK_LIMIT.
REQ-033 tro_stuck SHALL stay set until reset; collection continues while it is set.
REQ-034 With VN_EN=0, the stuck counter SHALL count consecutive equal successive accepted bits, including across the word boundary.

Reset
REQ-035 trng_rst_n=0 SHALL immediately force state IDLE and clear random_reg, rng_ready, tro_stuck, the shift register, all counters and the pair buffer.
REQ-036 Reset assertion mid-COLLECT or mid-GAP SHALL lose the partial word.
REQ-037 After trng_rst_n rises, the first COLLECT SHALL be no earlier than the first edge with enable_TRO=1.

Verification
REQ-038 Reset sequence: assert trng_rst_n=0 asynchronously between edges -> random_reg=0, rng_ready=0, tro_stuck=0 immediately; no rng_ready while enable_TRO=0 after release.
REQ-039 VN_EN=0: feed 0xd54f1f3d44c72ffd MSB-first on 64 consecutive raw_valid cycles -> rng_ready=1 for exactly one cycle, one cycle after the last strobe; random_reg=64'hd54f1f3d44c72ffd; samples during the following 6 GAP cycles are ignored.
REQ-040 VN_EN=1: feed 64 pairs "10" interleaved with 20 pairs "00"/"11" -> random_reg=64'hFFFFFFFFFFFFFFFF; pair "01" x64 -> random_reg=0.
REQ-041 Abort: accept 30 bits, drop enable_TRO for 2 cycles, re-raise, feed 64 bits of 0x23478dfe342ad745 -> single rng_ready; random_reg=64'h23478dfe342ad745.
REQ-042 Stuck: VN_EN=1, 128 consecutive pairs "11" -> tro_stuck=1 after the 128th pair, no rng_ready; a subsequent "10" pair leaves tro_stuck=1.
REQ-043 Back-to-back: 192 valid bits spanning three words -> three single-cycle rng_ready pulses separated by at least GAP_CYCLES+1 cycles, with correct words in order.
